// File: rtl/cache_arb_pkg.sv
// Shared types for the two-port cache arbiter: FSM states, port id and a
// saturating counter helper.
package cache_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef logic [0:0] port_id_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-way picker: a lone requester wins; a contest goes to the port that did
// not win last time, or always to port 1 when FIXED_PRIO is set.
module rr_pick2
  import cache_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  port_id_t             i_last_grant,
  output port_id_t             o_winner
);

  always_comb begin
    o_winner = 1'b0;
    if (&i_req) begin
      if (FIXED_PRIO != 0) o_winner = 1'b1;
      else                 o_winner = ~i_last_grant;
    end else if (i_req[1]) begin
      o_winner = 1'b1;
    end
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache between fetch (port 0) and load/store (port 1), holding the
// grant across a miss. Optional perf counters under CACHE_ARB_PERF_CNT_EN.
module cache_port_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_rd_req,
  input  logic              p0_wr_req,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wr_data,
  output logic              p0_stall,
  output logic              p0_rd_valid,
  output logic [DATA_W-1:0] p0_rd_data,
  input  logic              p1_rd_req,
  input  logic              p1_wr_req,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wr_data,
  output logic              p1_stall,
  output logic              p1_rd_valid,
  output logic [DATA_W-1:0] p1_rd_data,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_rd_req,
  output logic              c_wr_req,
  output logic [DATA_W-1:0] c_wr_data,
  input  logic              c_miss,
  input  logic [DATA_W-1:0] c_rd_data
`ifdef CACHE_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       p0_acc_cnt,
  output logic [31:0]       p1_acc_cnt,
  output logic [31:0]       p0_stall_cnt,
  output logic [31:0]       p1_stall_cnt
`endif
);

  logic [NUM_PORTS-1:0] w_req;
  arb_state_t           r_state, w_state_nxt;
  port_id_t             r_owner, r_last_grant, w_winner, w_port, r_pend_port;
  logic                 w_drive, w_accept, w_port_rd, w_port_wr, r_rd_pend;
  logic [DATA_W-1:0]    r_rd_data0, r_rd_data1;

  assign w_req = {p1_rd_req | p1_wr_req, p0_rd_req | p0_wr_req};

  rr_pick2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ARB_IDLE;
    else      r_state <= w_state_nxt;
  end

  // In OWN only the owner may reach the cache; if it drops its request we
  // fall back to IDLE without an accept.
  always_comb begin
    w_state_nxt = r_state;
    w_port      = w_winner;
    w_drive     = 1'b0;
    if (r_state == ARB_IDLE) begin
      w_drive = |w_req;
      if (w_drive && c_miss) w_state_nxt = ARB_OWN;
    end else begin
      w_port  = r_owner;
      w_drive = w_req[r_owner];
      if (!w_drive || !c_miss) w_state_nxt = ARB_IDLE;
    end
    if (!rst) w_drive = 1'b0;
  end

  assign w_accept  = w_drive & ~c_miss;
  assign w_port_rd = w_port ? p1_rd_req : p0_rd_req;
  assign w_port_wr = w_port ? p1_wr_req : p0_wr_req;

  assign c_rd_req  = w_drive & w_port_rd;
  assign c_wr_req  = w_drive & w_port_wr;
  assign c_addr    = w_drive ? (w_port ? p1_addr : p0_addr) : '0;
  assign c_wr_data = w_drive ? (w_port ? p1_wr_data : p0_wr_data) : '0;

  assign p0_stall  = w_req[0] & ~(w_accept & (w_port == 1'b0));
  assign p1_stall  = w_req[1] & ~(w_accept & (w_port == 1'b1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rd_pend    <= 1'b0;
      r_pend_port  <= 1'b0;
    end else begin
      if (r_state == ARB_IDLE && w_drive && c_miss) r_owner <= w_port;
      if (w_accept) r_last_grant <= w_port;
      r_rd_pend <= w_accept & w_port_rd;
      if (w_accept && w_port_rd) r_pend_port <= w_port;
    end
  end

  // Cache data arrives the cycle after accept; pass it straight through and
  // keep a copy so rd_data holds between returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data0 <= '0;
      r_rd_data1 <= '0;
    end else if (r_rd_pend) begin
      if (r_pend_port == 1'b0) r_rd_data0 <= c_rd_data;
      else                     r_rd_data1 <= c_rd_data;
    end
  end

  assign p0_rd_valid = r_rd_pend & (r_pend_port == 1'b0);
  assign p1_rd_valid = r_rd_pend & (r_pend_port == 1'b1);
  assign p0_rd_data  = p0_rd_valid ? c_rd_data : r_rd_data0;
  assign p1_rd_data  = p1_rd_valid ? c_rd_data : r_rd_data1;

`ifdef CACHE_ARB_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_acc_cnt   <= '0;
      p1_acc_cnt   <= '0;
      p0_stall_cnt <= '0;
      p1_stall_cnt <= '0;
    end else begin
      if (w_accept && w_port == 1'b0) p0_acc_cnt <= sat_inc32(p0_acc_cnt);
      if (w_accept && w_port == 1'b1) p1_acc_cnt <= sat_inc32(p1_acc_cnt);
      if (w_req[0] && p0_stall)       p0_stall_cnt <= sat_inc32(p0_stall_cnt);
      if (w_req[1] && p1_stall)       p1_stall_cnt <= sat_inc32(p1_stall_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench: a round-robin arbiter and a fixed-priority arbiter share the
// same stimulus; expected values are hand-derived per step.
module tb_cache_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst;
  logic          p0_rd_req, p0_wr_req, p1_rd_req, p1_wr_req, c_miss;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wr_data, p1_wr_data, c_rd_data;

  logic          p0_stall, p0_rd_valid, p1_stall, p1_rd_valid, c_rd_req, c_wr_req;
  logic [DW-1:0] p0_rd_data, p1_rd_data, c_wr_data;
  logic [AW-1:0] c_addr;

  logic          f_p0_stall, f_p0_rd_valid, f_p1_stall, f_p1_rd_valid, f_c_rd_req, f_c_wr_req;
  logic [DW-1:0] f_p0_rd_data, f_p1_rd_data, f_c_wr_data;
  logic [AW-1:0] f_c_addr;

`ifdef CACHE_ARB_PERF_CNT_EN
  logic [31:0] p0_acc_cnt, p1_acc_cnt, p0_stall_cnt, p1_stall_cnt;
  logic [31:0] f_p0_acc_cnt, f_p1_acc_cnt, f_p0_stall_cnt, f_p1_stall_cnt;
  logic [31:0] b_p0_acc, b_p1_acc, b_p0_stall, b_p1_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst(rst),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_stall(p0_stall), .p0_rd_valid(p0_rd_valid), .p0_rd_data(p0_rd_data),
    .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_stall(p1_stall), .p1_rd_valid(p1_rd_valid), .p1_rd_data(p1_rd_data),
    .c_addr(c_addr), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req), .c_wr_data(c_wr_data),
    .c_miss(c_miss), .c_rd_data(c_rd_data)
`ifdef CACHE_ARB_PERF_CNT_EN
    , .p0_acc_cnt(p0_acc_cnt), .p1_acc_cnt(p1_acc_cnt),
    .p0_stall_cnt(p0_stall_cnt), .p1_stall_cnt(p1_stall_cnt)
`endif
  );

  cache_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_f (
    .clk(clk), .rst(rst),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr), .p0_wr_data(p0_wr_data),
    .p0_stall(f_p0_stall), .p0_rd_valid(f_p0_rd_valid), .p0_rd_data(f_p0_rd_data),
    .p1_rd_req(p1_rd_req), .p1_wr_req(p1_wr_req), .p1_addr(p1_addr), .p1_wr_data(p1_wr_data),
    .p1_stall(f_p1_stall), .p1_rd_valid(f_p1_rd_valid), .p1_rd_data(f_p1_rd_data),
    .c_addr(f_c_addr), .c_rd_req(f_c_rd_req), .c_wr_req(f_c_wr_req), .c_wr_data(f_c_wr_data),
    .c_miss(c_miss), .c_rd_data(c_rd_data)
`ifdef CACHE_ARB_PERF_CNT_EN
    , .p0_acc_cnt(f_p0_acc_cnt), .p1_acc_cnt(f_p1_acc_cnt),
    .p0_stall_cnt(f_p0_stall_cnt), .p1_stall_cnt(f_p1_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required $finish before 200000");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    p0_rd_req = 1'b1; p0_wr_req = 1'b0; p0_addr = 32'h55; p0_wr_data = '0;
    p1_rd_req = 1'b0; p1_wr_req = 1'b0; p1_addr = '0;    p1_wr_data = '0;
    c_miss = 1'b0; c_rd_data = '0;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk);
    chk("rst_p0_stall", p0_stall, 1);
    chk("rst_p1_stall", p1_stall, 0);
    chk("rst_c_rd_req", c_rd_req, 0);
    chk("rst_c_addr", c_addr, 0);
    chk("rst_p0_rd_valid", p0_rd_valid, 0);
    chk("rst_p0_rd_data", p0_rd_data, 0);
`ifdef CACHE_ARB_PERF_CNT_EN
    chk("rst_p0_acc_cnt", p0_acc_cnt, 0);
    chk("rst_p1_stall_cnt", p1_stall_cnt, 0);
`endif

    // contested hits right after reset: p0, p1, p0
    nxt();
    rst = 1'b1;
    p0_rd_req = 1'b1; p0_addr = 32'h10;
    p1_rd_req = 1'b1; p1_addr = 32'h20;
    @(negedge clk);
    chk("s2c1_p0_stall", p0_stall, 0);
    chk("s2c1_p1_stall", p1_stall, 1);
    chk("s2c1_c_addr", c_addr, 32'h10);
    chk("s2c1_c_rd_req", c_rd_req, 1);
    chk("s2c1_fix_p1_stall", f_p1_stall, 0);
    chk("s2c1_fix_p0_stall", f_p0_stall, 1);
    nxt();
    p0_addr = 32'h14; c_rd_data = 32'hA0;
    @(negedge clk);
    chk("s2c2_p1_stall", p1_stall, 0);
    chk("s2c2_p0_stall", p0_stall, 1);
    chk("s2c2_c_addr", c_addr, 32'h20);
    chk("s2c2_p0_rd_valid", p0_rd_valid, 1);
    chk("s2c2_p0_rd_data", p0_rd_data, 32'hA0);
    nxt();
    p1_addr = 32'h24; c_rd_data = 32'hB0;
    @(negedge clk);
    chk("s2c3_p0_stall", p0_stall, 0);
    chk("s2c3_p1_stall", p1_stall, 1);
    chk("s2c3_c_addr", c_addr, 32'h14);
    chk("s2c3_p1_rd_valid", p1_rd_valid, 1);
    chk("s2c3_p1_rd_data", p1_rd_data, 32'hB0);
    chk("s2c3_p0_rd_valid", p0_rd_valid, 0);
    nxt();
    p0_rd_req = 1'b0; p1_rd_req = 1'b0; c_rd_data = 32'hC0;
    @(negedge clk);
    chk("s2c4_p0_rd_valid", p0_rd_valid, 1);
    chk("s2c4_p0_rd_data", p0_rd_data, 32'hC0);
    chk("s2c4_p1_rd_valid", p1_rd_valid, 0);
    chk("s2c4_c_rd_req", c_rd_req, 0);

    // lone port 0 read hit
    nxt();
    p0_rd_req = 1'b1; p0_addr = 32'h100; c_rd_data = '0;
    @(negedge clk);
    chk("s1_p0_stall", p0_stall, 0);
    chk("s1_c_addr", c_addr, 32'h100);
    chk("s1_c_rd_req", c_rd_req, 1);
    chk("s1_c_wr_req", c_wr_req, 0);
    chk("s1_p1_stall", p1_stall, 0);
    nxt();
    p0_rd_req = 1'b0; c_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("s1_p0_rd_valid", p0_rd_valid, 1);
    chk("s1_p0_rd_data", p0_rd_data, 32'hDEADBEEF);
    chk("s1_p1_rd_valid", p1_rd_valid, 0);
    chk("s1_p1_rd_data", p1_rd_data, 32'hB0);
    nxt();
    c_rd_data = 32'h5A5A;
    @(negedge clk);
    chk("s1_p0_rd_valid_drop", p0_rd_valid, 0);
    chk("s1_p0_rd_data_hold", p0_rd_data, 32'hDEADBEEF);

    // port 1 write misses for 20 cycles while port 0 waits
`ifdef CACHE_ARB_PERF_CNT_EN
    b_p0_acc = p0_acc_cnt; b_p1_acc = p1_acc_cnt;
    b_p0_stall = p0_stall_cnt; b_p1_stall = p1_stall_cnt;
`endif
    nxt();
    p1_wr_req = 1'b1; p1_addr = 32'h200; p1_wr_data = 32'h12345678;
    p0_rd_req = 1'b1; p0_addr = 32'h300; c_miss = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("s3_miss%0d_c_addr", i), c_addr, 32'h200);
      chk($sformatf("s3_miss%0d_c_wr_req", i), c_wr_req, 1);
      chk($sformatf("s3_miss%0d_p0_stall", i), p0_stall, 1);
      chk($sformatf("s3_miss%0d_p1_stall", i), p1_stall, 1);
      nxt();
    end
    c_miss = 1'b0;
    @(negedge clk);
    chk("s3_c21_p1_stall", p1_stall, 0);
    chk("s3_c21_p0_stall", p0_stall, 1);
    chk("s3_c21_c_addr", c_addr, 32'h200);
    chk("s3_c21_c_wr_data", c_wr_data, 32'h12345678);
    chk("s3_c21_c_rd_req", c_rd_req, 0);
    nxt();
    p1_wr_req = 1'b0;
    @(negedge clk);
    chk("s3_c22_p0_stall", p0_stall, 0);
    chk("s3_c22_c_addr", c_addr, 32'h300);
    chk("s3_c22_c_rd_req", c_rd_req, 1);
    chk("s3_c22_c_wr_req", c_wr_req, 0);
    chk("s3_c22_p1_rd_valid", p1_rd_valid, 0);
    nxt();
    p0_rd_req = 1'b0; c_rd_data = 32'h77;
    @(negedge clk);
    chk("s3_c23_p0_rd_valid", p0_rd_valid, 1);
    chk("s3_c23_p0_rd_data", p0_rd_data, 32'h77);
`ifdef CACHE_ARB_PERF_CNT_EN
    chk("s3_p1_acc_delta", p1_acc_cnt - b_p1_acc, 1);
    chk("s3_p0_acc_delta", p0_acc_cnt - b_p0_acc, 1);
    chk("s3_p0_stall_delta", p0_stall_cnt - b_p0_stall, 21);
    chk("s3_p1_stall_delta", p1_stall_cnt - b_p1_stall, 20);
`endif

    // continuous contested hits: fixed always picks p1, round-robin alternates
    nxt();
    p0_rd_req = 1'b1; p0_addr = 32'h400;
    p1_rd_req = 1'b1; p1_addr = 32'h500;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("s4_c%0d_fix_p1_stall", i), f_p1_stall, 0);
      chk($sformatf("s4_c%0d_fix_p0_stall", i), f_p0_stall, 1);
      chk($sformatf("s4_c%0d_fix_c_addr", i), f_c_addr, 32'h500);
      chk($sformatf("s4_c%0d_rr_p0_stall", i), p0_stall, (i % 2 == 0) ? 1 : 0);
      nxt();
    end
    p0_rd_req = 1'b0; p1_rd_req = 1'b0;

    // reset while port 1 owns the cache mid-miss
    p1_rd_req = 1'b1; p1_addr = 32'h600; c_miss = 1'b1;
    @(negedge clk);
    chk("s5_own_c_addr", c_addr, 32'h600);
    chk("s5_own_p1_stall", p1_stall, 1);
    nxt();
    p0_rd_req = 1'b1; p0_addr = 32'h700;
    @(negedge clk);
    chk("s5_own_hold_c_addr", c_addr, 32'h600);
    chk("s5_own_p0_stall", p0_stall, 1);
    #1 rst = 1'b0;
    #1;
    chk("s5_rst_p0_stall", p0_stall, 1);
    chk("s5_rst_p1_stall", p1_stall, 1);
    chk("s5_rst_c_rd_req", c_rd_req, 0);
    chk("s5_rst_c_addr", c_addr, 0);
    chk("s5_rst_p0_rd_valid", p0_rd_valid, 0);
    chk("s5_rst_p1_rd_valid", p1_rd_valid, 0);
    chk("s5_rst_p0_rd_data", p0_rd_data, 0);
`ifdef CACHE_ARB_PERF_CNT_EN
    chk("s5_rst_p1_acc_cnt", p1_acc_cnt, 0);
    chk("s5_rst_p0_stall_cnt", p0_stall_cnt, 0);
`endif
    nxt();
    rst = 1'b1; c_miss = 1'b0;
    @(negedge clk);
    chk("s5_rel_p0_stall", p0_stall, 0);
    chk("s5_rel_p1_stall", p1_stall, 1);
    chk("s5_rel_c_addr", c_addr, 32'h700);
    chk("s5_rel_fix_p1_stall", f_p1_stall, 0);
    chk("s5_rel_fix_p0_stall", f_p0_stall, 1);
    nxt();
    p0_rd_req = 1'b0; p1_rd_req = 1'b0;
    repeat (2) nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
